// File: rtl/uart_loopback_fifo_ctrl.sv
// uart_loopback_fifo_ctrl: ring buffer between a UART receiver and a UART
// transmitter, replayed through a trigger/busy handshake. Supports stream and
// line modes, overflow accounting, flush, and a deadlock-avoiding force drain.
// Optional build macro UART_LOOPBACK_CRLF_EN: a buffered terminator is
// preceded on the wire by a carriage return (8'h0D).
module uart_loopback_fifo_ctrl #(
  parameter int         DATA_WIDTH   = 8,
  parameter int         DEPTH        = 32,
  parameter logic [7:0] TERM_CHAR    = 8'h0A,
  parameter int         CNT_WIDTH    = 32,
  parameter int         BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_WIDTH-1:0]  rx_data,
  input  logic                   rx_valid,
  output logic [DATA_WIDTH-1:0]  tx_data,
  output logic                   tx_trigger,
  input  logic                   tx_busy,
  input  logic                   line_mode,
  input  logic                   flush,
  input  logic                   overflow_clr,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   rx_count,
  output logic [CNT_WIDTH-1:0]   tx_count,
  output logic [CNT_WIDTH-1:0]   drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] TERM     = DATA_WIDTH'(TERM_CHAR);
  localparam logic [TW-1:0]         TMO_LAST = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d, lines_q, lines_d;
  logic                  force_drain_q, force_drain_d;
  logic                  overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [TW-1:0]         tmo_q, tmo_d;

  logic                  push, drop, pop, go, send_cr, eligible;
  logic                  term_in, term_out;
  logic [DATA_WIDTH-1:0] head;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign fill_level = count_q;
  assign overflow   = overflow_q;
  assign rx_count   = rx_cnt_q;
  assign tx_count   = tx_cnt_q;
  assign drop_count = drop_cnt_q;
  assign tx_data    = tx_data_q;

  assign head = mem_q[rd_ptr_q];
  // full is registered, so a pop in the same cycle never makes room for a write
  assign push = rx_valid && !full && !flush;
  assign drop = rx_valid && full;
  // line_mode only matters in IDLE because eligibility is only consulted there
  assign eligible = !line_mode || (lines_q != '0) || force_drain_q;

`ifdef UART_LOOPBACK_CRLF_EN
  logic cr_sent_q, cr_sent_d;

  assign send_cr = go && (head == TERM) && !cr_sent_q;

  // Remember that the CR for the head terminator has already gone out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cr_sent_q <= 1'b0;
    else        cr_sent_q <= cr_sent_d;
  end

  // A CR issue sets the flag, the following real pop clears it
  always_comb begin
    cr_sent_d = cr_sent_q;
    if (send_cr)  cr_sent_d = 1'b1;
    else if (pop) cr_sent_d = 1'b0;
    if (flush)    cr_sent_d = 1'b0;
  end
`else
  assign send_cr = 1'b0;
`endif

  assign pop      = go && !send_cr;
  assign term_in  = push && (rx_data == TERM);
  assign term_out = pop && (head == TERM);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (go) state_d = ISSUE;
      ISSUE:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
                 else if (tmo_q == TMO_LAST) state_d = IDLE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM outputs: the issue decision (taken in IDLE) and the trigger pulse
  always_comb begin
    go         = (state_q == IDLE) && !tx_busy && !empty && eligible && !flush;
    tx_trigger = (state_q == ISSUE);
  end

  // Busy-rise timeout counter, only runs while waiting for busy
  always_comb begin
    tmo_d = '0;
    if (state_q == WAIT_BUSY) tmo_d = tmo_q + TW'(1);
  end

  // Buffer storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rx_data;
  end

  // Pointer, occupancy, line and drain bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    lines_d = lines_q;
    case ({term_in, term_out})
      2'b10:   lines_d = lines_q + CW'(1);
      2'b01:   lines_d = lines_q - CW'(1);
      default: lines_d = lines_q;
    endcase
    // a full buffer with no terminator could never drain in line mode
    force_drain_d = force_drain_q;
    if (empty)                                   force_drain_d = 1'b0;
    else if (full && line_mode && lines_q == '0) force_drain_d = 1'b1;
    if (flush) begin
      wr_ptr_d      = '0;
      rd_ptr_d      = '0;
      count_d       = '0;
      lines_d       = '0;
      force_drain_d = 1'b0;
    end
  end

  // Statistics, sticky overflow (set wins over clear) and the output byte
  always_comb begin
    rx_cnt_d   = rx_cnt_q + CNT_WIDTH'(push);
    tx_cnt_d   = tx_cnt_q + CNT_WIDTH'(go);
    drop_cnt_d = drop_cnt_q + CNT_WIDTH'(drop);
    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (overflow_clr) overflow_d = 1'b0;
    tx_data_d = tx_data_q;
    if (send_cr)  tx_data_d = DATA_WIDTH'(8'h0D);
    else if (pop) tx_data_d = head;
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      lines_q       <= '0;
      force_drain_q <= 1'b0;
      overflow_q    <= 1'b0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      drop_cnt_q    <= '0;
      tx_data_q     <= '0;
      tmo_q         <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      lines_q       <= lines_d;
      force_drain_q <= force_drain_d;
      overflow_q    <= overflow_d;
      rx_cnt_q      <= rx_cnt_d;
      tx_cnt_q      <= tx_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      tx_data_q     <= tx_data_d;
      tmo_q         <= tmo_d;
    end
  end

endmodule

// File: tb/tb_uart_loopback_fifo_ctrl.sv
// Bench for uart_loopback_fifo_ctrl: vector table, directed multi-cycle
// sequences and random traffic, all checked against a queue-based model.
module tb_uart_loopback_fifo_ctrl;

  localparam int DEPTH = 32;
  localparam logic [7:0] TERM = 8'h0A;
`ifdef UART_LOOPBACK_CRLF_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic        clk = 0, rst_n = 0;
  logic [7:0]  rx_data = 0, tx_data;
  logic        rx_valid = 0, tx_trigger, tx_busy = 0, line_mode = 0, flush = 0, overflow_clr = 0;
  logic        full, empty, overflow;
  logic [5:0]  fill_level;
  logic [31:0] rx_count, tx_count, drop_count;

  uart_loopback_fifo_ctrl #(.DATA_WIDTH(8), .DEPTH(DEPTH), .TERM_CHAR(TERM),
                            .CNT_WIDTH(32), .BUSY_TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_trigger(tx_trigger), .tx_busy(tx_busy),
    .line_mode(line_mode), .flush(flush), .overflow_clr(overflow_clr),
    .full(full), .empty(empty), .fill_level(fill_level), .overflow(overflow),
    .rx_count(rx_count), .tx_count(tx_count), .drop_count(drop_count));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  // reference model state
  logic [7:0] exp_q[$];
  bit m_ov = 0, m_cr = 0, trig_prev = 0, trig_seen = 0, hold_busy = 0;
  int m_rx = 0, m_tx = 0, m_drop = 0;
  int busy_left = 0, busy_len = 10;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // One clock: apply the inputs held across the edge to the model, then check.
  task automatic step();
    bit         v   = rx_valid;
    logic [7:0] d   = rx_data;
    bit         f   = flush;
    bit         oc  = overflow_clr;
    int         cnt0 = exp_q.size();
    bit         drp;
    logic [7:0] e;
    @(posedge clk); #1;
    trig_seen = tx_trigger;
    if (tx_trigger) begin
      chk("trigger_single_cycle", trig_prev, 0);
      chk("pop_from_nonempty", exp_q.size() > 0, 1);
      m_tx++;
      if (exp_q.size() > 0) begin
`ifdef UART_LOOPBACK_CRLF_EN
        if (exp_q[0] == TERM && !m_cr) begin
          chk("tx_data_cr", tx_data, 8'h0D);
          m_cr = 1;
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e);
          m_cr = 0;
        end
`else
        e = exp_q.pop_front();
        chk("tx_data", tx_data, e);
`endif
      end
    end
    trig_prev = tx_trigger;
    drp = v && (cnt0 == DEPTH);
    if (drp) begin m_drop++; m_ov = 1; end
    else if (oc) m_ov = 0;
    if (v && !drp && !f) begin exp_q.push_back(d); m_rx++; end
    if (f) begin exp_q.delete(); m_cr = 0; end
    chk("fill_level", fill_level, exp_q.size());
    chk("full", full, exp_q.size() == DEPTH);
    chk("empty", empty, exp_q.size() == 0);
    chk("overflow", overflow, m_ov);
    // transmitter model: busy for busy_len cycles after each trigger
    if (tx_trigger) busy_left = busy_len;
    else if (busy_left > 0) busy_left--;
    tx_busy = hold_busy || (busy_left > 0);
  endtask

  task automatic write_byte(input logic [7:0] b);
    rx_valid = 1; rx_data = b;
    step();
    rx_valid = 0;
  endtask

  task automatic wait_trig(input int max, input string nm);
    for (int i = 0; i < max; i++) begin
      step();
      if (trig_seen) return;
    end
    chk({nm, "_trigger_timeout"}, 0, 1);
  endtask

  // Count triggers over n cycles
  task automatic count_trigs(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (trig_seen) c++;
    end
  endtask

  // Run until the buffer is drained and the transmitter has been quiet a while
  task automatic settle();
    int q = 0;
    for (int i = 0; i < 600; i++) begin
      step();
      if (exp_q.size() == 0 && busy_left == 0 && !hold_busy) q++; else q = 0;
      if (q >= 8) return;
    end
    chk("settle_timeout", 0, 1);
  endtask

  typedef struct { logic [7:0] din; int blen; logic [7:0] exp; } vec_t;
  vec_t vecs[6];

  initial begin
    int c, rx0, tx0;
    vecs[0] = '{8'h41, 10, 8'h41};
    vecs[1] = '{8'h42, 10, 8'h42};
    vecs[2] = '{8'h43, 10, 8'h43};
    vecs[3] = '{8'h00,  0, 8'h00};
    vecs[4] = '{8'hFF,  3, 8'hFF};
    vecs[5] = '{8'h55,  1, 8'h55};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_trigger", tx_trigger, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_tx_count", tx_count, 0);
    chk("rst_drop_count", drop_count, 0);
    rst_n = 1;
    step();

    // vector table, stream mode
    foreach (vecs[i]) begin
      busy_len = vecs[i].blen;
      write_byte(vecs[i].din);
      wait_trig(40, "vec");
      chk("vec_tx_data", tx_data, vecs[i].exp);
      settle();
      if (i == 2) begin
        chk("abc_rx_count", rx_count, 3);
        chk("abc_tx_count", tx_count, 3);
        chk("abc_empty", empty, 1);
      end
    end

    // overflow: busy held, 33 writes, then release and drain across the wrap
    hold_busy = 1; tx_busy = 1; busy_len = 2;
    for (int i = 0; i < 33; i++) write_byte(8'h60 + 8'(i));
    chk("ovf_full", full, 1);
    chk("ovf_fill", fill_level, 32);
    chk("ovf_drop_count", drop_count, 1);
    chk("ovf_flag", overflow, 1);
    overflow_clr = 1; step(); overflow_clr = 0;
    chk("ovf_cleared", overflow, 0);
    hold_busy = 0; tx_busy = 0;
    count_trigs(400, c);
    chk("ovf_drained_count", c, 32);
    chk("ovf_empty", empty, 1);
    settle();

    // line mode: nothing leaves until the terminator arrives
    line_mode = 1; busy_len = 3;
    write_byte(8'h48);
    write_byte(8'h49);
    count_trigs(100, c);
    chk("line_held", c, 0);
    write_byte(TERM);
    count_trigs(100, c);
    chk("line_sent", c, 3 + EXTRA);
    // no complete line left, so a lone byte stays put
    write_byte(8'h58);
    count_trigs(60, c);
    chk("line_pending_zero", c, 0);
    flush = 1; step(); flush = 0;
    chk("line_flush_fill", fill_level, 0);

    // line mode force drain: a full unterminated buffer still empties
    for (int i = 0; i < 32; i++) write_byte(8'h20 + 8'(i));
    count_trigs(400, c);
    chk("drain_count", c, 32);
    chk("drain_empty", empty, 1);
    write_byte(8'h59);
    count_trigs(60, c);
    chk("drain_cleared", c, 0);
    flush = 1; step(); flush = 0;
    line_mode = 0;
    settle();

    // flush during an in-flight transmission
    hold_busy = 1; tx_busy = 1;
    for (int i = 0; i < 6; i++) write_byte(8'hA0 + 8'(i));
    hold_busy = 0; tx_busy = 0; busy_len = 10;
    wait_trig(20, "flush");
    repeat (3) step();
    chk("flush_pre_fill", fill_level, 5);
    rx0 = m_rx; tx0 = m_tx;
    flush = 1; step(); flush = 0;
    chk("flush_fill", fill_level, 0);
    chk("flush_rx_count", rx_count, rx0);
    count_trigs(60, c);
    chk("flush_no_trigger", c, 0);
    chk("flush_tx_count", tx_count, tx0);
    chk("flush_busy_done", tx_busy, 0);

    // random stream traffic
    for (int i = 0; i < 1500; i++) begin
      rx_valid     = ($urandom % 2) == 1;
      rx_data      = 8'($urandom);
      flush        = ($urandom % 97) == 0;
      overflow_clr = ($urandom % 16) == 0;
      busy_len     = $urandom_range(0, 6);
      step();
    end
    rx_valid = 0; flush = 0; overflow_clr = 0;
    settle();
    chk("rand_rx_count", rx_count, m_rx);
    chk("rand_tx_count", tx_count, m_tx);
    chk("rand_drop_count", drop_count, m_drop);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
